// File: rtl/apb_cmd_master_if.sv
// Command/response stream plus APB4 requester bus for apb_cmd_master.
// "master" is the view of the APB requester itself; "slave" is the view of
// everything around it (local controller on the cmd/rsp side, APB target on the p* side).
interface apb_cmd_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  // command stream from the local controller
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH+1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [3:0]            cmd_strb;

  // response stream back to the local controller
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  // APB4 requester signals
  logic [ADDR_WIDTH+1:0] paddr;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [3:0]            pstrb;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pready;
  logic                  pslverr;
  logic [DATA_WIDTH-1:0] prdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output paddr, psel, penable, pwrite, pstrb, pwdata,
    input  pready, pslverr, prdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  paddr, psel, penable, pwrite, pstrb, pwdata,
    output pready, pslverr, prdata
  );
endinterface

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB4 requester: cmd stream -> SETUP/ACCESS -> rsp stream.
// Latency: zero-wait round trip 3 cycles accept-to-rsp_valid, +1 per wait state; misaligned 1 cycle.
// Backpressure: cmd_ready only in IDLE; rsp held stable until rsp_ready; ACCESS aborts after TIMEOUT_CYCLES waits.
module apb_cmd_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic               pclk,
  input logic               prst,
  apb_cmd_master_if.master  bus
);

  localparam int AW    = ADDR_WIDTH + 2;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                state_q, state_d;

  // APB outputs are registered; paddr/pwrite/pwdata/pstrb double as the command latch
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [AW-1:0]         paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [3:0]            pstrb_q, pstrb_d;

  // response registers
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  // ACCESS wait-state counter, saturating
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      cnt_inc;
  logic                  timeout_hit;

  logic                  cmd_ready;
  logic                  cmd_fire;
  logic                  misaligned;

  // Accept only in IDLE and never while reset is held
  assign cmd_ready  = (state_q == IDLE) && !prst;
  assign cmd_fire   = bus.cmd_valid && cmd_ready;
  assign misaligned = (bus.cmd_addr[1:0] != 2'b00);

  // Counter value after one more wait cycle, clamped at all-ones so it never wraps
  assign cnt_inc     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (int'(cnt_inc) >= TIMEOUT_CYCLES);

  // Next-state and next-output logic; every register holds unless a transition says otherwise
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          if (misaligned) begin
            // rejected locally, the APB bus never sees it
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d   = SETUP;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            paddr_d   = bus.cmd_addr;
            pwrite_d  = bus.cmd_write;
            pwdata_d  = bus.cmd_wdata;
            // APB4: strobes must be low on reads
            pstrb_d   = bus.cmd_write ? bus.cmd_strb : 4'b0000;
          end
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end

      ACCESS: begin
        if (bus.pready) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = bus.pslverr;
          // error responses and writes never carry data
          rsp_rdata_d = (pwrite_q || bus.pslverr) ? '0 : bus.prdata;
        end else begin
          cnt_d = cnt_inc;
          if (timeout_hit) begin
            state_d     = RESP;
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
          cnt_d       = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset kills any transfer in flight without a response
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= 4'b0000;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.pstrb     = pstrb_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: directed vector table, randomized commands vs. a transaction-level model,
// and a reset-during-ACCESS sequence. The bench plays both the local controller and the APB target.
module tb_apb_cmd_master;

  localparam int DW     = 32;
  localparam int AW     = 10;
  localparam int TO     = 16;
  localparam int BUDGET = 200;

  logic pclk;
  logic prst;

  apb_cmd_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  apb_cmd_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .pclk (pclk),
    .prst (prst),
    .bus  (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int tests = 0;
  int fails = 0;

  // one command plus how the APB target and the consumer behave for it
  typedef struct {
    logic          write;
    logic [AW+1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    strb;
    int            waits;      // pready comes on ACCESS cycle waits+1
    logic          slverr;
    logic [DW-1:0] prdata;
    int            rsp_delay;  // cycles rsp_ready is held low once rsp_valid is seen
  } cmd_t;

  // what the bench saw / expects for one transaction
  typedef struct {
    int            lat;        // edges from accept to rsp_valid
    int            setup_n;
    int            access_n;
    logic          err;
    logic [DW-1:0] rdata;
    logic [AW+1:0] paddr;
    logic          pwrite;
    logic [3:0]    pstrb;
    logic [DW-1:0] pwdata;
    logic          stable;     // APB outputs steady for the whole transfer
    logic          hold_ok;    // response steady, bus idle, no new accept while in RESP
    logic          idle_after; // back to accepting right after the response handshake
    logic          timed_out;
  } obs_t;

  typedef struct {
    cmd_t          c;
    int            lat;
    int            access_n;
    logic          err;
    logic [DW-1:0] rdata;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic cmd_t mk_cmd(input logic w, input logic [AW+1:0] a, input logic [DW-1:0] d,
                                  input logic [3:0] s, input int waits, input logic se,
                                  input logic [DW-1:0] rd, input int dly);
    cmd_t c;
    c.write = w; c.addr = a; c.wdata = d; c.strb = s;
    c.waits = waits; c.slverr = se; c.prdata = rd; c.rsp_delay = dly;
    return c;
  endfunction

  function automatic vec_t mk_vec(input cmd_t c, input int lat, input int acc,
                                  input logic err, input logic [DW-1:0] rd);
    vec_t v;
    v.c = c; v.lat = lat; v.access_n = acc; v.err = err; v.rdata = rd;
    return v;
  endfunction

  // Transaction-level model: what a command should produce, from the protocol rules alone
  function automatic obs_t model(input cmd_t c);
    obs_t e;
    logic [AW+1:0] a;
    logic timeout;
    a = c.addr;
    e.stable = 1'b1; e.hold_ok = 1'b1; e.idle_after = 1'b1; e.timed_out = 1'b0;
    e.paddr = c.addr; e.pwrite = c.write; e.pwdata = c.wdata;
    e.pstrb = c.write ? c.strb : 4'b0000;
    if (a[1:0] != 2'b00) begin
      e.lat = 1; e.setup_n = 0; e.access_n = 0; e.err = 1'b1; e.rdata = '0;
    end else begin
      timeout    = (TO > 0) && (c.waits >= TO);
      e.setup_n  = 1;
      e.access_n = timeout ? TO : c.waits + 1;
      e.lat      = e.access_n + 2;
      e.err      = timeout || c.slverr;
      e.rdata    = (e.err || c.write) ? '0 : c.prdata;
    end
    return e;
  endfunction

  // Drive one command, act as APB target, then consume the response. Called at posedge+1.
  task automatic run_cmd(input cmd_t c, output obs_t o);
    int  k;
    bit  done;
    bit  captured;
    o.lat = 0; o.setup_n = 0; o.access_n = 0; o.err = 1'b0; o.rdata = '0;
    o.paddr = '0; o.pwrite = 1'b0; o.pstrb = '0; o.pwdata = '0;
    o.stable = 1'b1; o.hold_ok = 1'b1; o.idle_after = 1'b0; o.timed_out = 1'b0;
    captured = 0;

    bus.cmd_valid = 1'b1;
    bus.cmd_write = c.write;
    bus.cmd_addr  = c.addr;
    bus.cmd_wdata = c.wdata;
    bus.cmd_strb  = c.strb;
    k = 0;
    while (!bus.cmd_ready && k < BUDGET) begin
      @(posedge pclk); #1; k++;
    end
    if (!bus.cmd_ready) begin
      bus.cmd_valid = 1'b0;
      o.timed_out = 1'b1;
      return;
    end
    @(posedge pclk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = 12'($urandom);
    bus.cmd_wdata = $urandom;
    bus.cmd_strb  = 4'($urandom);

    k = 1; done = 0;
    while (!done && k < BUDGET) begin
      if (bus.rsp_valid) begin
        done = 1;
        o.lat = k;
      end else begin
        if (bus.psel) begin
          if (!captured) begin
            captured = 1;
            o.paddr = bus.paddr; o.pwrite = bus.pwrite; o.pstrb = bus.pstrb; o.pwdata = bus.pwdata;
          end else if (bus.paddr !== o.paddr || bus.pwrite !== o.pwrite ||
                       bus.pstrb !== o.pstrb || bus.pwdata !== o.pwdata) begin
            o.stable = 1'b0;
          end
        end
        if (bus.psel && bus.penable) begin
          o.access_n++;
          if (o.access_n > c.waits) begin
            bus.pready = 1'b1; bus.pslverr = c.slverr; bus.prdata = c.prdata;
          end else begin
            bus.pready = 1'b0; bus.pslverr = 1'($urandom); bus.prdata = $urandom;
          end
        end else begin
          if (bus.psel) o.setup_n++;
          // target noise outside ACCESS must be ignored
          bus.pready = 1'($urandom); bus.pslverr = 1'($urandom); bus.prdata = $urandom;
        end
        @(posedge pclk); #1; k++;
      end
    end
    bus.pready = 1'b0; bus.pslverr = 1'b0;
    if (!done) begin
      o.timed_out = 1'b1;
      return;
    end

    o.err = bus.rsp_err;
    o.rdata = bus.rsp_rdata;
    if (bus.psel || bus.penable || bus.cmd_ready) o.hold_ok = 1'b0;
    for (int i = 0; i < c.rsp_delay; i++) begin
      bus.rsp_ready = 1'b0;
      @(posedge pclk); #1;
      if (!bus.rsp_valid || bus.rsp_err !== o.err || bus.rsp_rdata !== o.rdata ||
          bus.cmd_ready || bus.psel)
        o.hold_ok = 1'b0;
    end
    // rsp_ready is left high afterwards: the consumer may hold it permanently
    bus.rsp_ready = 1'b1;
    @(posedge pclk); #1;
    o.idle_after = !bus.rsp_valid && bus.cmd_ready;
  endtask

  task automatic check_obs(input string tag, input cmd_t c, input obs_t o, input obs_t e);
    check({tag, ".no_hang"}, o.timed_out, 0);
    check({tag, ".latency"}, o.lat, e.lat);
    check({tag, ".setup_cycles"}, o.setup_n, e.setup_n);
    check({tag, ".access_cycles"}, o.access_n, e.access_n);
    check({tag, ".rsp_err"}, o.err, e.err);
    check({tag, ".rsp_rdata"}, o.rdata, e.rdata);
    check({tag, ".apb_stable"}, o.stable, 1);
    check({tag, ".rsp_hold"}, o.hold_ok, 1);
    check({tag, ".idle_after"}, o.idle_after, 1);
    if (e.setup_n != 0) begin
      check({tag, ".paddr"}, o.paddr, e.paddr);
      check({tag, ".pwrite"}, o.pwrite, e.pwrite);
      check({tag, ".pstrb"}, o.pstrb, e.pstrb);
      if (c.write) check({tag, ".pwdata"}, o.pwdata, e.pwdata);
    end
  endtask

  vec_t vecs[10];

  initial begin
    cmd_t c;
    obs_t o;
    obs_t e;
    int   k;
    bit   flag;

    vecs[0] = mk_vec(mk_cmd(1'b1, 12'h010, 32'hDEADBEEF, 4'b1111, 0,   1'b0, 32'h0,        0), 3,  1,  1'b0, 32'h0);
    vecs[1] = mk_vec(mk_cmd(1'b0, 12'h010, 32'h0,        4'b1111, 2,   1'b0, 32'hDEADBEEF, 0), 5,  3,  1'b0, 32'hDEADBEEF);
    vecs[2] = mk_vec(mk_cmd(1'b0, 12'h013, 32'h0,        4'b0000, 0,   1'b0, 32'h55555555, 0), 1,  0,  1'b1, 32'h0);
    vecs[3] = mk_vec(mk_cmd(1'b0, 12'h020, 32'h0,        4'b0000, 100, 1'b0, 32'h77777777, 1), 18, 16, 1'b1, 32'h0);
    vecs[4] = mk_vec(mk_cmd(1'b1, 12'h024, 32'h01020304, 4'b0101, 0,   1'b1, 32'h0,        5), 3,  1,  1'b1, 32'h0);
    vecs[5] = mk_vec(mk_cmd(1'b0, 12'h030, 32'h0,        4'b1111, 15,  1'b0, 32'h12345678, 0), 18, 16, 1'b0, 32'h12345678);
    vecs[6] = mk_vec(mk_cmd(1'b0, 12'h034, 32'h0,        4'b0000, 16,  1'b0, 32'h9ABCDEF0, 0), 18, 16, 1'b1, 32'h0);
    vecs[7] = mk_vec(mk_cmd(1'b1, 12'h002, 32'hFFFFFFFF, 4'b1111, 0,   1'b0, 32'h0,        2), 1,  0,  1'b1, 32'h0);
    vecs[8] = mk_vec(mk_cmd(1'b0, 12'hFFC, 32'h0,        4'b1010, 1,   1'b0, 32'hA5A5A5A5, 2), 4,  2,  1'b0, 32'hA5A5A5A5);
    vecs[9] = mk_vec(mk_cmd(1'b0, 12'h040, 32'h0,        4'b0000, 0,   1'b1, 32'h11112222, 0), 3,  1,  1'b1, 32'h0);

    prst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0; bus.cmd_strb = '0;
    bus.rsp_ready = 1'b0; bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = '0;

    // reset state
    repeat (2) @(posedge pclk);
    #1;
    check("reset.psel", bus.psel, 0);
    check("reset.penable", bus.penable, 0);
    check("reset.pwrite", bus.pwrite, 0);
    check("reset.pstrb", bus.pstrb, 0);
    check("reset.paddr", bus.paddr, 0);
    check("reset.pwdata", bus.pwdata, 0);
    check("reset.rsp_valid", bus.rsp_valid, 0);
    check("reset.rsp_err", bus.rsp_err, 0);
    check("reset.rsp_rdata", bus.rsp_rdata, 0);
    check("reset.cmd_ready", bus.cmd_ready, 0);
    prst = 1'b0;
    @(posedge pclk); #1;
    check("post_reset.cmd_ready", bus.cmd_ready, 1);

    // directed vectors
    for (int i = 0; i < 10; i++) begin
      run_cmd(vecs[i].c, o);
      e = model(vecs[i].c);
      e.lat = vecs[i].lat; e.access_n = vecs[i].access_n;
      e.err = vecs[i].err; e.rdata = vecs[i].rdata;
      check_obs($sformatf("vec%0d", i), vecs[i].c, o, e);
    end

    // reset while the target stalls in ACCESS
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 12'h050; bus.cmd_strb = 4'hF;
    bus.pready = 1'b0;
    k = 0;
    while (!bus.cmd_ready && k < BUDGET) begin @(posedge pclk); #1; k++; end
    @(posedge pclk); #1;
    bus.cmd_valid = 1'b0;
    k = 0;
    while (!(bus.psel && bus.penable) && k < 20) begin @(posedge pclk); #1; k++; end
    check("rst_mid.reached_access", bus.psel && bus.penable, 1);
    @(posedge pclk); #2;
    prst = 1'b1;
    #1;
    check("rst_mid.psel", bus.psel, 0);
    check("rst_mid.penable", bus.penable, 0);
    check("rst_mid.rsp_valid", bus.rsp_valid, 0);
    check("rst_mid.cmd_ready", bus.cmd_ready, 0);
    @(posedge pclk); #3;
    prst = 1'b0;
    @(posedge pclk); #1;
    check("rst_mid.cmd_ready_after", bus.cmd_ready, 1);
    flag = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.rsp_valid || bus.psel) flag = 1;
      @(posedge pclk); #1;
    end
    check("rst_mid.no_stale_rsp", flag, 0);
    c = mk_cmd(1'b0, 12'h050, 32'h0, 4'hF, 1, 1'b0, 32'hCAFEF00D, 0);
    run_cmd(c, o);
    check_obs("rst_mid.fresh_read", c, o, model(c));

    // randomized commands against the model
    for (int n = 0; n < 40; n++) begin
      c.write  = 1'($urandom);
      c.addr   = 12'($urandom);
      if ($urandom_range(0, 5) != 0) c.addr[1:0] = 2'b00;
      c.wdata  = $urandom;
      c.strb   = 4'($urandom);
      c.waits  = ($urandom_range(0, 4) == 0) ? $urandom_range(13, 20) : $urandom_range(0, 3);
      c.slverr = ($urandom_range(0, 7) == 0);
      c.prdata = $urandom;
      c.rsp_delay = $urandom_range(0, 3);
      run_cmd(c, o);
      check_obs($sformatf("rand%0d", n), c, o, model(c));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got no end, expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
